// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced capture of operands/operation and registration of the add/sub result with flags
module alu_operand_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_data,
  input  logic       sw_op,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [3:0] aplusb,
  input  logic [3:0] aminusb,
  output logic [3:0] a_val,
  output logic [3:0] b_val,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       flag_zero,
  output logic       flag_neg,
  output logic       flag_ovf,
  output logic [1:0] state_led
);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, CALC = 2'b10, SHOW = 2'b11} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  state_t state_q;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0] lvl_q, lvl_d, rise_q, mis;
  logic [3:0] a_q, b_q, res_q, sel;
  logic op_q, valid_q, zero_q, neg_q, ovf_q, ovf_c, enter_p, clear_p;
  // index 0 is ENTER, index 1 is CLEAR; a level flips on the DEBOUNCE_CYCLES-th consecutive mismatch
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mis[i] = sync_q[i][SYNC_STAGES-1] != lvl_q[i];
      cnt_d[i] = (mis[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
      lvl_d[i] = (mis[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? ~lvl_q[i] : lvl_q[i];
    end
  end
  assign enter_p = rise_q[0];
  assign clear_p = rise_q[1];
  assign sel     = op_q ? aminusb : aplusb;
  assign ovf_c   = (op_q ? (a_q[3] != b_q[3]) : (a_q[3] == b_q[3])) & (sel[3] != a_q[3]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[1][SYNC_STAGES-2:0], btn_clear, sync_q[0][SYNC_STAGES-2:0], btn_enter};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear_p) begin
        a_q     <= '0;
        b_q     <= '0;
        res_q   <= '0;
        zero_q  <= 1'b0;
        neg_q   <= 1'b0;
        ovf_q   <= 1'b0;
        state_q <= WAIT_A;
      end else begin
        case (state_q)
          WAIT_A: if (enter_p) begin
            a_q     <= sw_data;
            state_q <= WAIT_B;
          end
          WAIT_B: if (enter_p) begin
            b_q     <= sw_data;
            op_q    <= sw_op;
            state_q <= CALC;
          end
          CALC: begin
            res_q   <= sel;
            zero_q  <= sel == 4'd0;
            neg_q   <= sel[3];
            ovf_q   <= ovf_c;
            valid_q <= 1'b1;
            state_q <= SHOW;
          end
          default: if (enter_p) state_q <= WAIT_A;
        endcase
      end
    end
  end
  assign a_val        = a_q;
  assign b_val        = b_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign flag_zero    = zero_q;
  assign flag_neg     = neg_q;
  assign flag_ovf     = ovf_q;
  assign state_led    = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: randomized press sequences checked against a transaction-level model
module tb_alu_operand_sequencer;
  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int HOLD = SS + DB + 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] sw_data = '0;
  logic sw_op = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic [3:0] aplusb, aminusb, a_val, b_val, result;
  logic result_valid, flag_zero, flag_neg, flag_ovf;
  logic [1:0] state_led;
  int n_cmp = 0, n_err = 0, rv_cnt = 0;
  int m_st = 0, m_rv = 0;
  logic [3:0] m_a = '0, m_b = '0, m_res = '0;
  logic m_zero = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;

  alu_operand_sequencer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .aplusb(aplusb), .aminusb(aminusb), .a_val(a_val), .b_val(b_val),
    .result(result), .result_valid(result_valid), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .flag_ovf(flag_ovf), .state_led(state_led)
  );

  assign aplusb  = a_val + b_val;
  assign aminusb = a_val - b_val;
  always #5 clk = ~clk;
  always @(posedge clk) if (result_valid) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_enter(input logic [3:0] d, input logic op);
    int sa, sb, t;
    if (m_st == 0) begin
      m_a = d;
      m_st = 1;
    end else if (m_st == 1) begin
      m_b = d;
      sa = m_a[3] ? int'(m_a) - 16 : int'(m_a);
      sb = m_b[3] ? int'(m_b) - 16 : int'(m_b);
      t = op ? sa - sb : sa + sb;
      m_res = 4'(t);
      m_ovf = (t > 7) || (t < -8);
      m_zero = m_res == 4'd0;
      m_neg = m_res[3];
      m_rv++;
      m_st = 3;
    end else m_st = 0;
  endtask

  task automatic model_clear();
    m_a = '0; m_b = '0; m_res = '0;
    m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
    m_st = 0;
  endtask

  task automatic press(input logic [3:0] d, input logic op);
    sw_data = d;
    sw_op = op;
    btn_enter = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_enter = 1'b0;
    sw_data = 4'($urandom);
    sw_op = 1'($urandom);
    repeat (HOLD) @(negedge clk);
    model_enter(d, op);
  endtask

  task automatic clear(input logic with_enter);
    btn_clear = 1'b1;
    btn_enter = with_enter;
    repeat (HOLD) @(negedge clk);
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_clear();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_val"}, a_val, m_a);
    chk({tag, ".b_val"}, b_val, m_b);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".zero"}, flag_zero, m_zero);
    chk({tag, ".neg"}, flag_neg, m_neg);
    chk({tag, ".ovf"}, flag_ovf, m_ovf);
    chk({tag, ".state"}, state_led, m_st);
    chk({tag, ".valid_pulses"}, rv_cnt, m_rv);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);
    press(4'd3, 1'b0); press(4'd5, 1'b0);
    check_all("t1");
    chk("t1.result_const", result, 4'd8);
    chk("t1.ovf_const", flag_ovf, 1'b1);
    press(4'd0, 1'b0);
    press(4'd3, 1'b0); press(4'd5, 1'b1);
    check_all("t2");
    chk("t2.result_const", result, 4'hE);
    press(4'd0, 1'b0);
    press(4'h8, 1'b0); press(4'd1, 1'b1);
    check_all("t3a");
    chk("t3a.result_const", result, 4'd7);
    press(4'd0, 1'b0);
    press(4'd2, 1'b1); press(4'hE, 1'b0);
    check_all("t3b");
    chk("t3b.zero_const", flag_zero, 1'b1);
    press(4'd0, 1'b0);
    sw_data = 4'd9;
    btn_enter = 1'b1;
    repeat (DB - 1) @(negedge clk);
    btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_all("bounce");
    press(4'd9, 1'b0);
    check_all("bounce_clean");
    clear(1'b0);
    check_all("clear_wait_b");
    press(4'd6, 1'b0);
    clear(1'b1);
    check_all("clear_enter");
    chk("clear_enter.a_zero", a_val, 4'd0);
    press(4'd7, 1'b0);
    sw_data = 4'd1;
    sw_op = 1'b0;
    btn_enter = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (state_led == 2'b10) hit = 1'b1;
    end
    chk("calc_reached", hit, 1'b1);
    #1 rst = 1'b1;
    btn_enter = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(4'd3, 1'b0); press(4'd5, 1'b0);
    check_all("after_rst");
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 7) == 0) clear(1'($urandom));
      else press(4'($urandom), 1'($urandom));
      check_all("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
